// File: rtl/branch_predict_ctrl_pkg.sv
// Shared encodings for the branch predictor: 2-bit counter states, controller
// FSM states and the saturating counter step.
package branch_predict_ctrl_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
        ctr_t nxt;
        nxt = cur;
        if (taken) begin
            if (cur != CTR_ST) nxt = ctr_t'(cur + 2'd1);
        end else begin
            if (cur != CTR_SNT) nxt = ctr_t'(cur - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predict_ctrl_history_table.sv
// Array of 2-bit saturating counters: combinational read, synchronous
// saturating update, asynchronous reset to weakly-not-taken.
module branch_history_table
    import branch_predict_ctrl_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] i_rd_idx,
    output ctr_t             o_rd_ctr,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    ctr_t r_table [ENTRIES];

    // No write-to-read bypass: a same-cycle read sees the old counter.
    assign o_rd_ctr = r_table[i_rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) r_table[i] <= CTR_WNT;
        end else if (i_wr_en) begin
            r_table[i_wr_idx] <= ctr_next(r_table[i_wr_idx], i_wr_taken);
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Fetch-stage branch predictor with execute-stage resolution, PC redirect,
// timed IF/ID flush after a mispredict, and branch statistics.
module branch_predict_ctrl
    import branch_predict_ctrl_pkg::*;
#(
    parameter int BHT_ENTRIES  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        if_valid,
    input  logic        if_is_branch,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_imm_target,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_taken,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_flush_cnt;
    logic               r_flush;
    logic               r_redirect_valid;
    logic [31:0]        r_redirect_pc;
    logic [31:0]        r_branch_count;
    logic [31:0]        r_mispredict_count;

    ctr_t               w_rd_ctr;
    logic [IDX_W-1:0]   w_rd_idx;
    logic [IDX_W-1:0]   w_wr_idx;
    logic               w_resolve;
    logic               w_mispredict;

    assign w_rd_idx     = if_pc[IDX_W+1:2];
    assign w_wr_idx     = ex_pc[IDX_W+1:2];
    assign w_resolve    = ex_valid & ex_is_branch & ~stall & (r_state == ST_IDLE);
    assign w_mispredict = w_resolve & (ex_taken != ex_pred_taken);

    branch_history_table #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rd_idx   (w_rd_idx),
        .o_rd_ctr   (w_rd_ctr),
        .i_wr_en    (w_resolve),
        .i_wr_idx   (w_wr_idx),
        .i_wr_taken (ex_taken)
    );

    assign pred_taken  = if_valid & if_is_branch & (w_rd_ctr inside {CTR_WT, CTR_ST});
    assign pred_target = pred_taken ? if_imm_target : (if_pc + 32'd4);

    // Flush counter counts down from FLUSH_CYCLES-1 and freezes during stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_flush_cnt      <= '0;
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_redirect_valid <= w_mispredict;
            case (r_state)
                ST_IDLE: begin
                    if (w_mispredict) begin
                        r_state       <= ST_FLUSH;
                        r_flush       <= 1'b1;
                        r_flush_cnt   <= CNT_W'(FLUSH_CYCLES - 1);
                        r_redirect_pc <= ex_taken ? ex_target : (ex_pc + 32'd4);
                    end
                end
                ST_FLUSH: begin
                    if (!stall) begin
                        if (r_flush_cnt == '0) begin
                            r_state <= ST_IDLE;
                            r_flush <= 1'b0;
                        end else begin
                            r_flush_cnt <= r_flush_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_flush <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (w_resolve)    r_branch_count     <= r_branch_count + 32'd1;
            if (w_mispredict) r_mispredict_count <= r_mispredict_count + 32'd1;
        end
    end

    assign redirect_valid   = r_redirect_valid;
    assign redirect_pc      = r_redirect_pc;
    assign flush            = r_flush;
    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl with hand-computed expectations.
module tb_branch_predict_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        if_valid, if_is_branch;
    logic [31:0] if_pc, if_imm_target;
    logic        ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] branch_count, mispredict_count;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    branch_predict_ctrl #(
        .BHT_ENTRIES  (16),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .if_valid         (if_valid),
        .if_is_branch     (if_is_branch),
        .if_pc            (if_pc),
        .if_imm_target    (if_imm_target),
        .ex_valid         (ex_valid),
        .ex_is_branch     (ex_is_branch),
        .ex_taken         (ex_taken),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pc            (ex_pc),
        .ex_target        (ex_target),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .flush            (flush),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [31:0] tgt,
                           input logic taken, input logic ptaken);
        ex_valid      = 1'b1;
        ex_is_branch  = 1'b1;
        ex_pc         = pc;
        ex_target     = tgt;
        ex_taken      = taken;
        ex_pred_taken = ptaken;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0;
        if_valid = 1'b1; if_is_branch = 1'b1;
        if_pc = 32'h100; if_imm_target = 32'h200;
        ex_valid = 1'b0; ex_is_branch = 1'b0; ex_taken = 1'b0; ex_pred_taken = 1'b0;
        ex_pc = '0; ex_target = '0;
        #22 rst_n = 1'b1;
        step();

        // Reset state and first prediction
        chk("rst_pred_taken",  32'(pred_taken), 32'd0);
        chk("rst_pred_target", pred_target, 32'h104);
        chk("rst_redir_valid", 32'(redirect_valid), 32'd0);
        chk("rst_redir_pc",    redirect_pc, 32'h0);
        chk("rst_flush",       32'(flush), 32'd0);
        chk("rst_branch_cnt",  branch_count, 32'd0);
        chk("rst_mispred_cnt", mispredict_count, 32'd0);

        // Taken resolve predicted not-taken at 0x100: mispredict, WNT->WT
        resolve(32'h100, 32'h200, 1'b1, 1'b0);
        step();
        ex_valid = 1'b0;
        chk("m1_redir_valid", 32'(redirect_valid), 32'd1);
        chk("m1_redir_pc",    redirect_pc, 32'h200);
        chk("m1_flush",       32'(flush), 32'd1);
        step();
        chk("m1_redir_drop",  32'(redirect_valid), 32'd0);
        chk("m1_flush_c2",    32'(flush), 32'd1);
        step();
        chk("m1_flush_end",   32'(flush), 32'd0);
        resolve(32'h100, 32'h200, 1'b1, 1'b1);
        step();
        ex_valid = 1'b0;
        chk("t2_pred_taken",  32'(pred_taken), 32'd1);
        chk("t2_pred_target", pred_target, 32'h200);
        chk("t2_branch_cnt",  branch_count, 32'd2);
        chk("t2_mispred_cnt", mispredict_count, 32'd1);

        // Index 0 is at ST: walk it down, checking saturation at 00
        resolve(32'h100, 32'h200, 1'b0, 1'b0);
        chk("nobypass_st", 32'(pred_taken), 32'd1);
        step();
        chk("nt1_wt", 32'(pred_taken), 32'd1);
        chk("nobypass_wt", 32'(pred_taken), 32'd1);
        step();
        chk("nt2_wnt", 32'(pred_taken), 32'd0);
        step();
        step();
        resolve(32'h100, 32'h200, 1'b1, 1'b1);
        step();
        chk("sat_lo_wnt", 32'(pred_taken), 32'd0);
        step();
        step();
        step();
        resolve(32'h100, 32'h200, 1'b0, 1'b0);
        step();
        ex_valid = 1'b0;
        chk("sat_hi_wt", 32'(pred_taken), 32'd1);
        chk("sat_branch_cnt",  branch_count, 32'd11);
        chk("sat_mispred_cnt", mispredict_count, 32'd1);

        // Not-taken mispredict at 0x40; branch offered during flush is ignored
        resolve(32'h40, 32'h80, 1'b0, 1'b1);
        step();
        chk("m2_redir_valid", 32'(redirect_valid), 32'd1);
        chk("m2_redir_pc",    redirect_pc, 32'h44);
        chk("m2_flush",       32'(flush), 32'd1);
        chk("m2_branch_cnt",  branch_count, 32'd12);
        chk("m2_mispred_cnt", mispredict_count, 32'd2);
        resolve(32'h50, 32'h90, 1'b1, 1'b0);
        step();
        chk("m2_redir_drop",  32'(redirect_valid), 32'd0);
        chk("m2_flush_c2",    32'(flush), 32'd1);
        chk("m2_redir_hold",  redirect_pc, 32'h44);
        if_pc = 32'h50;
        #1;
        chk("m2_ignored_bht", 32'(pred_taken), 32'd0);
        ex_valid = 1'b0;
        step();
        chk("m2_flush_end",   32'(flush), 32'd0);
        chk("m2_ignored_cnt", branch_count, 32'd12);
        chk("m2_ignored_mis", mispredict_count, 32'd2);

        // Counter wrap with preload, plus stall stretching the flush
        force dut.r_mispredict_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_mispredict_count;
        resolve(32'h60, 32'h300, 1'b1, 1'b0);
        step();
        ex_valid = 1'b0;
        stall = 1'b1;
        chk("wrap_mispred_cnt", mispredict_count, 32'd0);
        chk("wrap_redir_pc",    redirect_pc, 32'h300);
        chk("st_flush_c1",      32'(flush), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("st_flush_stall%0d", i), 32'(flush), 32'd1);
        end
        stall = 1'b0;
        step();
        chk("st_flush_c5", 32'(flush), 32'd1);
        step();
        chk("st_flush_end", 32'(flush), 32'd0);
        chk("st_branch_cnt", branch_count, 32'd13);

        // Asynchronous reset in the middle of a flush
        resolve(32'h70, 32'h400, 1'b1, 1'b0);
        step();
        ex_valid = 1'b0;
        if_pc = 32'h70;
        #1;
        chk("ar_pre_flush", 32'(flush), 32'd1);
        chk("ar_pre_pred",  32'(pred_taken), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_flush",       32'(flush), 32'd0);
        chk("ar_redir_valid", 32'(redirect_valid), 32'd0);
        chk("ar_redir_pc",    redirect_pc, 32'h0);
        chk("ar_branch_cnt",  branch_count, 32'd0);
        chk("ar_mispred_cnt", mispredict_count, 32'd0);
        chk("ar_bht_70",      32'(pred_taken), 32'd0);
        if_pc = 32'h100;
        #1;
        chk("ar_bht_100",     32'(pred_taken), 32'd0);
        #2 rst_n = 1'b1;
        step();
        step();
        chk("ar_post_flush",  32'(flush), 32'd0);
        chk("ar_post_target", pred_target, 32'h104);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/branch_predict_ctrl.md
BRANCH_PREDICT_CTRL -- requirements
Module: branch_predict_ctrl

Interface
REQ-001 Parameter BHT_ENTRIES, default 16: number of 2-bit counters; SHALL be a power of two.
REQ-002 Parameter FLUSH_CYCLES, default 2: number of cycles flush is held after a mispredict; SHALL be at least 1.
REQ-003 Ports SHALL be: clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  asynchronous reset, active-low.
REQ-005 stall  in  1  pipeline stall: freezes resolution, FSM and counters.
REQ-006 if_valid, if_is_branch  in  1 each  fetch-stage instruction valid / predecoded conditional branch.
REQ-007 if_pc, if_imm_target  in  32 each  fetch PC / PC+B-immediate.
REQ-008 ex_valid, ex_is_branch, ex_taken, ex_pred_taken  in  1 each  execute-stage valid, branch flag, comparator result, prediction carried from fetch.
REQ-009 ex_pc, ex_target  in  32 each  execute PC / computed branch target.
REQ-010 pred_taken  out  1  fetch prediction.
REQ-011 pred_target  out  32  next fetch PC.
REQ-012 redirect_valid  out  1  single-cycle PC-correction pulse.
REQ-013 redirect_pc  out  32  corrected PC.
REQ-014 flush  out  1  kill IF/ID stages.
REQ-015 branch_count, mispredict_count  out  32 each  statistics counters.

Function
REQ-016 Prediction SHALL be combinational: pred_taken = if_valid & if_is_branch & bht[idx][1], with idx = if_pc[log2(BHT_ENTRIES)+1:2].
REQ-017 pred_target SHALL be if_imm_target when pred_taken, else if_pc+4 (mod 2^32).
REQ-018 A resolve SHALL occur in a cycle where ex_valid & ex_is_branch & ~stall hold and the FSM is in IDLE.
REQ-019 A mispredict SHALL be a resolve with ex_taken != ex_pred_taken.
REQ-020 On a resolve, bht[ex_pc index] SHALL increment if ex_taken, else decrement, saturating at 3 and 0; the update is visible from the next cycle.
REQ-021 A same-cycle read and update of the same index SHALL return the pre-update value (no bypass).
REQ-022 FSM states SHALL be IDLE and FLUSH; reset state is IDLE.
REQ-023 IDLE -> FLUSH on a mispredict at edge N; FLUSH lasts FLUSH_CYCLES cycles, then returns to IDLE.
REQ-024 While stall is high, the flush-cycle counter SHALL hold its value.
REQ-025 redirect_valid SHALL be registered: high for exactly the first cycle after edge N, then low.
REQ-026 redirect_pc SHALL be captured at edge N as ex_target if ex_taken, else ex_pc+4, and held until the next mispredict.
REQ-027 flush SHALL be high exactly while the FSM is in FLUSH.
REQ-028 Execute inputs SHALL be ignored while in FLUSH: no BHT update, no count increment, no new redirect.
REQ-029 branch_count SHALL increment on every resolve; mispredict_count SHALL increment on every mispredict.
REQ-030 Both statistics counters SHALL wrap from 0xFFFFFFFF to 0.
REQ-031 Resolves with ex_valid=0 or ex_is_branch=0 SHALL have no effect.

Reset
REQ-032 rst_n low SHALL asynchronously force: FSM=IDLE, all BHT entries=01 (weakly not-taken), redirect_valid=0, redirect_pc=0, flush=0, branch_count=0, mispredict_count=0.
REQ-033 Reset asserted mid-FLUSH SHALL abort the flush immediately.
REQ-034 Logic SHALL leave reset on the first rising clk edge after rst_n rises.

Structure
REQ-035 The counter encodings (SNT=00, WNT=01, WT=10, ST=11) and the FSM state encodings SHALL live in the shared defines header.
REQ-036 The counter array SHALL be a sub-module branch_history_table: one combinational read port, one synchronous saturating-update port, and async reset to WNT.

Verification
REQ-037 Reset release, if_pc=0x100, if_is_branch=1 -> pred_taken=0, pred_target=0x104, all outputs zero.
REQ-038 Two taken resolves at ex_pc=0x100 with ex_pred_taken=0 then 1 -> one mispredict; then fetch 0x100 with if_imm_target=0x200 -> pred_taken=1, pred_target=0x200; branch_count=2, mispredict_count=1.
REQ-039 Mispredict: ex_taken=0, ex_pred_taken=1, ex_pc=0x40 -> redirect_valid for 1 cycle with redirect_pc=0x44; flush for 2 cycles; second branch offered in cycle N+1 ignored (branch_count increments by 1 only).
REQ-040 Four not-taken resolves on one index -> counter saturates at 00, no underflow; four taken resolves -> saturates at 11.
REQ-041 stall=1 during FLUSH for 3 cycles -> flush held 2+3 cycles total; preload mispredict_count=0xFFFFFFFF, then one mispredict -> wraps to 0.
REQ-042 rst_n pulsed low mid-FLUSH, asynchronously to clk -> flush=0 immediately; BHT returns to WNT.
